// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing core. It combines the pixel-enable divider,
//               the x/y raster counters, the sync/blank decode and a delay
//               pipeline. The pipeline lines up sync/blank with the
//               framebuffer read latency.
// Ports       : CLK_40      - system clock, all logic on posedge
//               reset       - synchronous, active-high reset
//               pix_en      - one-cycle pixel tick enable
//               x_pos/y_pos - current (undelayed) raster position
//               active      - combinational, position is inside visible area
//               hsync/vsync - delayed syncs with configurable polarity
//               blank       - delayed blanking flag (1 = drive black)
//               line_start  - pulse when x_pos becomes 0
//               frame_start - pulse when (x_pos,y_pos) becomes (0,0)
//               frame_count - frames completed since reset, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int   PIX_DIV    = 1,
  parameter int   H_AREA     = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 128,
  parameter int   H_BP       = 88,
  parameter int   V_AREA     = 600,
  parameter int   V_FP       = 1,
  parameter int   V_SYNC     = 4,
  parameter int   V_BP       = 23,
  parameter logic HSYNC_POL  = 1'b1,
  parameter logic VSYNC_POL  = 1'b1,
  parameter int   PIPE_DELAY = 2,
  parameter int   FRAME_W    = 8,
  localparam int  H_TOTAL    = H_AREA + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_AREA + V_FP + V_SYNC + V_BP,
  localparam int  X_W        = $clog2(H_TOTAL),
  localparam int  Y_W        = $clog2(V_TOTAL)
) (
  input  logic               CLK_40,
  input  logic               reset,
  output logic               pix_en,
  output logic [X_W-1:0]     x_pos,
  output logic [Y_W-1:0]     y_pos,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int                DIV_W      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(PIX_DIV - 1);
  localparam logic [X_W-1:0]    c_x_last   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]    c_y_last   = Y_W'(V_TOTAL - 1);
  localparam logic [31:0]       c_h_area   = 32'(H_AREA);
  localparam logic [31:0]       c_v_area   = 32'(V_AREA);
  localparam logic [31:0]       c_hs_start = 32'(H_AREA + H_FP);
  localparam logic [31:0]       c_hs_end   = 32'(H_AREA + H_FP + H_SYNC);
  localparam logic [31:0]       c_vs_start = 32'(V_AREA + V_FP);
  localparam logic [31:0]       c_vs_end   = 32'(V_AREA + V_FP + V_SYNC);
  // Pipeline entry layout {hs, vs, bl}; idle means syncs off and blanked.
  localparam logic [2:0]        c_idle     = 3'b001;

  logic [DIV_W-1:0]              r_div_cnt;
  logic                          r_pix_en;
  logic [X_W-1:0]                r_x_pos;
  logic [Y_W-1:0]                r_y_pos;
  logic                          r_line_start;
  logic                          r_frame_start;
  logic [FRAME_W-1:0]            r_frame_count;
  logic [PIPE_DELAY-1:0][2:0]    r_pipe;

  logic                          w_div_last;
  logic                          w_x_wrap;
  logic                          w_y_wrap;
  logic [31:0]                   w_x_ext;
  logic [31:0]                   w_y_ext;
  logic                          w_active;
  logic [2:0]                    w_raw;
  logic [2:0]                    w_last;

  assign w_div_last = (r_div_cnt == c_div_last);
  assign w_x_wrap   = (r_x_pos == c_x_last);
  assign w_y_wrap   = (r_y_pos == c_y_last);

  // Decode in 32 bits so the end of a window may equal 2**X_W without overflow.
  assign w_x_ext  = 32'(r_x_pos);
  assign w_y_ext  = 32'(r_y_pos);
  assign w_active = (w_x_ext < c_h_area) && (w_y_ext < c_v_area);
  assign w_raw    = {(w_x_ext >= c_hs_start) && (w_x_ext < c_hs_end),
                     (w_y_ext >= c_vs_start) && (w_y_ext < c_vs_end),
                     ~w_active};

  // Pixel-tick divider. When PIX_DIV is 1 the counter stays at 0, so pix_en
  // stays high from the second cycle after reset.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_pix_en  <= w_div_last;
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  // Raster counters. The start pulses are set on the same edge that loads
  // the zero, so each pulse lines up with the first cycle showing the new
  // position.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_x_pos       <= '0;
      r_y_pos       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (r_pix_en) begin
        if (w_x_wrap) begin
          r_x_pos      <= '0;
          r_line_start <= 1'b1;
          if (w_y_wrap) begin
            r_y_pos       <= '0;
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + FRAME_W'(1);
          end else begin
            r_y_pos <= r_y_pos + Y_W'(1);
          end
        end else begin
          r_x_pos <= r_x_pos + X_W'(1);
        end
      end
    end
  end

  // Sync/blank delay line. It advances once per pixel tick, so the outputs
  // hold their value between ticks.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_pipe <= {PIPE_DELAY{c_idle}};
    end else if (r_pix_en) begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_last      = r_pipe[PIPE_DELAY-1];
  assign hsync       = w_last[2] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = w_last[1] ? VSYNC_POL : ~VSYNC_POL;
  assign blank       = w_last[0];
  assign active      = w_active;
  assign pix_en      = r_pix_en;
  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen. It drives three
//               configurations from a shared clock and reset. The expected
//               outputs come from a closed-form model: position, pulses and
//               delayed decode are derived from the number of clock edges
//               since the last reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb, pd, hp, vp, fw;
  } cfg_t;

  typedef struct {
    int pe, x, y, act, hs, vs, bl, ls, fs, fc;
  } exp_t;

  // A: small raster, PIX_DIV 1, positive syncs
  // B: small raster, PIX_DIV 3, negative syncs, deeper pipe, 2-bit frame count
  // C: default raster with PIX_DIV 4
  cfg_t c_cfg_a = '{1, 8, 2, 3, 1, 4, 1, 2, 1, 2, 1, 1, 8};
  cfg_t c_cfg_b = '{3, 8, 2, 3, 1, 4, 1, 2, 1, 3, 0, 0, 2};
  cfg_t c_cfg_c = '{4, 800, 40, 128, 88, 600, 1, 4, 23, 2, 1, 1, 8};

  logic CLK_40 = 1'b0;
  logic reset  = 1'b1;

  always #5 CLK_40 = ~CLK_40;

  logic       a_pe, a_act, a_hs, a_vs, a_bl, a_ls, a_fs;
  logic [3:0] a_x;
  logic [2:0] a_y;
  logic [7:0] a_fc;
  logic       b_pe, b_act, b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic [1:0] b_fc;
  logic        c_pe, c_act, c_hs, c_vs, c_bl, c_ls, c_fs;
  logic [10:0] c_x;
  logic [9:0]  c_y;
  logic [7:0]  c_fc;

  vga_timing_gen #(
    .PIX_DIV(1), .H_AREA(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_AREA(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(2), .FRAME_W(8)
  ) u_dut_a (
    .CLK_40(CLK_40), .reset(reset), .pix_en(a_pe), .x_pos(a_x), .y_pos(a_y),
    .active(a_act), .hsync(a_hs), .vsync(a_vs), .blank(a_bl),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .PIX_DIV(3), .H_AREA(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_AREA(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(3), .FRAME_W(2)
  ) u_dut_b (
    .CLK_40(CLK_40), .reset(reset), .pix_en(b_pe), .x_pos(b_x), .y_pos(b_y),
    .active(b_act), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .PIX_DIV(4)
  ) u_dut_c (
    .CLK_40(CLK_40), .reset(reset), .pix_en(c_pe), .x_pos(c_x), .y_pos(c_y),
    .active(c_act), .hsync(c_hs), .vsync(c_vs), .blank(c_bl),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   k     = 0;   // clock edges since the last reset edge

  // Expected outputs after edge k (k = 0 is the reset edge). pix_en is high
  // after edge k when k is a nonzero multiple of div. The counters have then
  // seen t = (k-1)/div ticks. The delayed outputs decode the position of
  // tick t - pd.
  function automatic exp_t model(input cfg_t c, input int kk);
    exp_t e;
    int ht, vt, ft, t, pos, p2, x2, y2, pe_prev;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    ft = ht * vt;
    t  = (kk == 0) ? 0 : (kk - 1) / c.div;
    pos     = t % ft;
    e.pe    = (kk > 0 && kk % c.div == 0) ? 1 : 0;
    pe_prev = (kk > 1 && (kk - 1) % c.div == 0) ? 1 : 0;
    e.x   = pos % ht;
    e.y   = pos / ht;
    e.fc  = (t / ft) % (1 << c.fw);
    e.ls  = (pe_prev == 1 && t % ht == 0) ? 1 : 0;
    e.fs  = (pe_prev == 1 && t % ft == 0) ? 1 : 0;
    e.act = (e.x < c.ha && e.y < c.va) ? 1 : 0;
    if (t < c.pd) begin
      e.hs = 1 - c.hp;
      e.vs = 1 - c.vp;
      e.bl = 1;
    end else begin
      p2 = (t - c.pd) % ft;
      x2 = p2 % ht;
      y2 = p2 / ht;
      e.hs = (x2 >= c.ha + c.hf && x2 < c.ha + c.hf + c.hs) ? c.hp : 1 - c.hp;
      e.vs = (y2 >= c.va + c.vf && y2 < c.va + c.vf + c.vs) ? c.vp : 1 - c.vp;
      e.bl = (x2 < c.ha && y2 < c.va) ? 0 : 1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic pe,
                     input logic [31:0] x, input logic [31:0] y, input logic act,
                     input logic hs, input logic vs, input logic bl,
                     input logic ls, input logic fs, input logic [31:0] fc);
    chk({tag, ".pix_en"},      32'(pe),  e.pe);
    chk({tag, ".x_pos"},       x,        e.x);
    chk({tag, ".y_pos"},       y,        e.y);
    chk({tag, ".active"},      32'(act), e.act);
    chk({tag, ".hsync"},       32'(hs),  e.hs);
    chk({tag, ".vsync"},       32'(vs),  e.vs);
    chk({tag, ".blank"},       32'(bl),  e.bl);
    chk({tag, ".line_start"},  32'(ls),  e.ls);
    chk({tag, ".frame_start"}, 32'(fs),  e.fs);
    chk({tag, ".frame_count"}, fc,       e.fc);
  endtask

  // Drive one edge and queue the state the DUTs should show after it.
  task automatic step(input logic rst);
    @(negedge CLK_40);
    reset = rst;
    k = rst ? 0 : k + 1;
    qa.push_back(model(c_cfg_a, k));
    qb.push_back(model(c_cfg_b, k));
    qc.push_back(model(c_cfg_c, k));
  endtask

  // Monitor: every output is presented every cycle; sample 1 after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_40);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("A", e, a_pe, 32'(a_x), 32'(a_y), a_act, a_hs, a_vs, a_bl, a_ls, a_fs, 32'(a_fc));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("B", e, b_pe, 32'(b_x), 32'(b_y), b_act, b_hs, b_vs, b_bl, b_ls, b_fs, 32'(b_fc));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp("C", e, c_pe, 32'(c_x), 32'(c_y), c_act, c_hs, c_vs, c_bl, c_ls, c_fs, 32'(c_fc));
      end
    end
  end

  // Stimulus
  initial begin
    exp_t cur;
    bit   found;
    repeat (3) step(1'b1);
    // Long clean run: several frames on A, frame_count wrap on B.
    repeat (1500) step(1'b0);
    // Reset in the middle of the visible area of A (x=5, y=3).
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cur = model(c_cfg_a, k);
      if (cur.x == 5 && cur.y == 3) begin
        found = 1'b1;
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL midframe_reset: position x=5 y=3 not reached, got 0 expected 1");
    end
    repeat (1200) step(1'b0);
    // Random reset pulses of 1..3 cycles scattered through the run.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    @(posedge CLK_40);
    #2;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size() + qc.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the discrete pixel-enable divider, hsync_gen and vsync_gen blocks; merges them into one timing core.
- Contains:
  - the pixel-enable divider;
  - the x/y raster counters;
  - sync and blank decode with configurable polarity;
  - a configurable-depth delay pipeline that aligns sync/blank with frame-buffer read latency.
- Sits between CLK_40 and the framebuffer read / RGB output stage.
- x_pos/y_pos drive memory addressing; the delayed syncs drive the connector.

Parameters:
- PIX_DIV, 1: CLK_40 cycles per pixel tick. Minimum 1.
- H_AREA, 800: active pixels per line.
- H_FP, 40: horizontal front porch, in pixels.
- H_SYNC, 128: hsync pulse width, in pixels.
- H_BP, 88: horizontal back porch, in pixels.
- V_AREA, 600: active lines per frame.
- V_FP, 1: vertical front porch, in lines.
- V_SYNC, 4: vsync pulse width, in lines.
- V_BP, 23: vertical back porch, in lines.
- HSYNC_POL, 1: level driven on hsync while asserted.
- VSYNC_POL, 1: level driven on vsync while asserted.
- PIPE_DELAY, 2: pixel ticks of delay applied to hsync/vsync/blank. Minimum 1.
- FRAME_W, 8: width of frame_count.
- Derived (not overridable): H_TOTAL = H_AREA+H_FP+H_SYNC+H_BP; V_TOTAL likewise; X_W = $clog2(H_TOTAL); Y_W = $clog2(V_TOTAL).

Ports:
- CLK_40  in  1  system clock. All logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- pix_en  out  1  pixel-tick clock enable, high for one CLK_40 cycle.
- x_pos  out  X_W  current pixel column (undelayed).
- y_pos  out  Y_W  current line (undelayed).
- active  out  1  combinational: (x_pos < H_AREA) && (y_pos < V_AREA).
- hsync  out  1  delayed horizontal sync.
- vsync  out  1  delayed vertical sync.
- blank  out  1  delayed blanking flag; 1 means drive black.
- line_start  out  1  one-cycle pulse when x_pos becomes 0.
- frame_start  out  1  one-cycle pulse when (x_pos,y_pos) becomes (0,0).
- frame_count  out  FRAME_W  frames completed since reset; wraps.

Behaviour:
- Reset values (reset is synchronous, active-high, on CLK_40):
  - divider counter 0, pix_en 0;
  - x_pos 0, y_pos 0;
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, blank 1;
  - line_start 0, frame_start 0, frame_count 0;
  - the whole delay pipeline is filled with the deasserted values (sync deasserted, blank 1).
- Divider:
  - Counts 0..PIX_DIV-1 and wraps.
  - pix_en is registered, high in the cycle after the counter equals PIX_DIV-1.
  - PIX_DIV=1: pix_en is 0 in the first cycle after reset, then constantly 1.
- Counters advance only in cycles where pix_en=1:
  - x_pos increments.
  - When x_pos == H_TOTAL-1: x_pos → 0 and y_pos increments.
  - When additionally y_pos == V_TOTAL-1: y_pos → 0 and frame_count increments modulo 2^FRAME_W.
- line_start and frame_start:
  - line_start is high for exactly the CLK_40 cycle in which x_pos first reads 0 after a wrap.
  - frame_start is high for the cycle in which (0,0) first appears after a wrap.
  - Both are asserted together at a frame wrap.
  - Neither pulses on reset release.
- Raw decode of the current (x_pos,y_pos):
  - hs_raw = x in [H_AREA+H_FP, H_AREA+H_FP+H_SYNC).
  - vs_raw = y in [V_AREA+V_FP, V_AREA+V_FP+V_SYNC); level-based on y only, so it changes at the line wrap.
  - bl_raw = !active.
- Delay pipeline:
  - A PIPE_DELAY-deep shift register of {hs_raw, vs_raw, bl_raw}, shifted only when pix_en=1.
  - Outputs are taken from the last stage with polarity applied: hsync = stage ? HSYNC_POL : ~HSYNC_POL; vsync likewise with VSYNC_POL; blank = stage value.
  - Outputs therefore reflect the counter state PIPE_DELAY pixel ticks earlier.
  - Outputs hold between pix_en pulses.
- Reset asserted mid-frame: all state returns to the reset values on the next edge; no partial pulse survives.
- No other state. All outputs except active are registered.

Test Plan:
- Reset defaults: assert reset for 3 cycles with defaults → after release, x_pos=0, y_pos=0, hsync=0 (POL=1), vsync=0, blank=1, frame_count=0, line_start=0, frame_start=0; pix_en=1 from the second cycle after release.
- Divider: PIX_DIV=4 → pix_en high 1 cycle in every 4; x_pos increments exactly once per pulse; across 40 cycles after release x_pos reaches 10.
- Small raster (H 8/2/3/1 → H_TOTAL 14; V 4/1/2/1 → V_TOTAL 8; PIX_DIV=1, PIPE_DELAY=2):
  - hsync asserts 2 cycles after x_pos first reads 10 and stays for 3 cycles;
  - blank rises 2 cycles after x_pos reads 8;
  - vsync covers lines 5–6, delayed by 2 ticks.
- Wrap and counters: run 3 frames (3×112 ticks) on the small raster → frame_start pulses exactly 3 times, each coincident with line_start; frame_count=3; line_start pulses 24 times.
- Polarity: HSYNC_POL=0, VSYNC_POL=0 → both idle high after reset and pulse low over the same windows as the small-raster case.
- Mid-frame reset: assert reset at x=5, y=3 during vsync-inactive active video → next cycle all outputs are at reset values; the following frame timing is identical to that after the initial reset.
